uart_tx_fifo: RTL

- Transmit end of the board's serial link: buffers bytes produced by the command interface FSM and serialises them as 8N1 UART frames on the TX pin.
- Paced by the shared baud_rate_gen tick (16x oversampling), the same tick used by the receive path.
- Replaces the constant tx_full = 0 with a real full flag, so the interface FSM must hold off when the buffer is full.

---
 rtl/uart_tx_fifo.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular-buffer front end.
// Bytes pushed on wr are queued and then sent as 8N1 frames on tx, paced by a
// 16x oversampling tick. full/empty let the producer throttle itself.
module uart_tx_fifo #(
    parameter int NB_DATA = 8,   // data bits per frame and FIFO word width
    parameter int W       = 4,   // FIFO address bits, depth = 2**W
    parameter int SB_TICK = 16   // s_ticks in the stop bit
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_tick,
    input  logic               wr,
    input  logic [NB_DATA-1:0] w_data,
    output logic               full,
    output logic               empty,
    output logic               busy,
    output logic               tx_done_tick,
    output logic               tx
);

    localparam int DEPTH = 2 ** W;
    // The tick counter must reach 15 for data bits and SB_TICK-1 for the stop bit.
    localparam int CW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(15);
    localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
    localparam logic [NW-1:0] IDX_LAST  = NW'(NB_DATA - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [NB_DATA-1:0] mem [DEPTH];
    logic [W-1:0]       w_ptr, r_ptr;
    logic [W-1:0]       w_ptr_inc, r_ptr_inc;
    logic               push, pop;

    assign w_ptr_inc = w_ptr + W'(1);
    assign r_ptr_inc = r_ptr + W'(1);
    // A write into a full buffer is only taken when the transmitter frees a slot
    // in the same cycle.
    assign push = wr & (~full | pop);

    // Storage write port.
    // NOTE: the storage array is deliberately not reset; the pointers and flags
    // alone decide which words are valid, and a resettable array costs a lot.
    always_ff @(posedge clk) begin
        if (push) mem[w_ptr] <= w_data;
    end

    // Pointer and occupancy-flag update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            case ({push, pop})
                2'b10: begin
                    w_ptr <= w_ptr_inc;
                    empty <= 1'b0;
                    full  <= (w_ptr_inc == r_ptr);
                end
                2'b01: begin
                    r_ptr <= r_ptr_inc;
                    full  <= 1'b0;
                    empty <= (r_ptr_inc == w_ptr);
                end
                2'b11: begin
                    // Occupancy unchanged, so both flags hold.
                    w_ptr <= w_ptr_inc;
                    r_ptr <= r_ptr_inc;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t             state, state_next;
    logic [CW-1:0]      s_reg, s_next;
    logic [NW-1:0]      n_reg, n_next;
    logic [NB_DATA-1:0] b_reg, b_next;
    logic               tx_next;

    // State, counters, shift register and registered line output.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s_reg <= '0;
            n_reg <= '0;
            b_reg <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_next;
            s_reg <= s_next;
            n_reg <= n_next;
            b_reg <= b_next;
            tx    <= tx_next;
        end
    end

    // Next-state, counter and pop decisions.
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred; blocking assignments are correct here.
    always_comb begin
        state_next   = state;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        pop          = 1'b0;
        tx_done_tick = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    b_next     = mem[r_ptr];
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + CW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == IDX_LAST) state_next = STOP;
                        else                   n_next     = n_reg + NW'(1);
                    end else begin
                        s_next = s_reg + CW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        s_next = s_reg + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level for the state being entered, so tx is registered yet aligned
    // with the state it belongs to.
    always_comb begin
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
